// File: rtl/dec_digit_serializer_if.sv
// Digit-in / ASCII-out bundle for the decimal serializer.
// slave = serializer side, master = driver/sink side.
interface dec_digit_serializer_if;
  logic [3:0] i_digit;
  logic       i_digit_rd;
  logic       i_conv_rd;
  logic [7:0] o_char;
  logic       o_char_stb;
  logic       i_char_rdy;
  logic       o_busy;
  logic       o_done;
  logic       o_err;

  modport slave (
    input  i_digit,
    input  i_digit_rd,
    input  i_conv_rd,
    input  i_char_rdy,
    output o_char,
    output o_char_stb,
    output o_busy,
    output o_done,
    output o_err
  );

  modport master (
    output i_digit,
    output i_digit_rd,
    output i_conv_rd,
    output i_char_rdy,
    input  o_char,
    input  o_char_stb,
    input  o_busy,
    input  o_done,
    input  o_err
  );
endinterface

// File: rtl/dec_digit_serializer.sv
// Collects LSB-first BCD digits into a LIFO and replays
// them MSB-first as ASCII bytes, plus optional terminator.
module dec_digit_serializer #(
  parameter int         DEPTH     = 3,
  parameter bit         TERM_EN   = 1'b1,
  parameter logic [7:0] TERM_CHAR = 8'h0A
) (
  input logic clk,
  input logic rst,
  dec_digit_serializer_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    COLLECT,
    EMIT,
    TERM,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] count;
  logic [CW-1:0] top;
  logic [3:0]    stack [DEPTH];
  logic [3:0]    cur;
  logic          cur_bad;
  logic          err;

  assign top     = count - ONE;
  assign cur     = stack[top];
  assign cur_bad = cur > 4'd9;
  assign bus.o_err = err;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_nx;
  end

  // Next state and byte-stream outputs
  always_comb begin
    state_nx       = state;
    bus.o_char     = 8'h00;
    bus.o_char_stb = 1'b0;
    bus.o_busy     = 1'b0;
    bus.o_done     = 1'b0;
    unique case (state)
      COLLECT: begin
        if (bus.i_conv_rd && !bus.i_digit_rd
            && count != '0)
          state_nx = EMIT;
      end
      EMIT: begin
        bus.o_char_stb = 1'b1;
        bus.o_busy     = 1'b1;
        bus.o_char     = cur_bad ? 8'h3F
                       : 8'h30 + {4'h0, cur};
        if (bus.i_char_rdy && count == ONE)
          state_nx = TERM_EN ? TERM : DONE;
      end
      TERM: begin
        bus.o_char_stb = 1'b1;
        bus.o_busy     = 1'b1;
        bus.o_char     = TERM_CHAR;
        if (bus.i_char_rdy) state_nx = DONE;
      end
      DONE: begin
        bus.o_done = 1'b1;
        state_nx   = COLLECT;
      end
      default: state_nx = COLLECT;
    endcase
  end

  // Digit stack, count and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      unique case (state)
        COLLECT: begin
          if (bus.i_digit_rd) begin
            if (count != FULL) begin
              stack[count] <= bus.i_digit;
              count        <= count + ONE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (cur_bad || bus.i_digit_rd) err <= 1'b1;
          if (bus.i_char_rdy) count <= count - ONE;
        end
        TERM: begin
          if (bus.i_digit_rd) err <= 1'b1;
        end
        DONE: begin
          count <= '0;
          if (bus.i_digit_rd) err <= 1'b1;
        end
        default: count <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_digit_serializer.sv
// Directed bench for dec_digit_serializer: vector table,
// exhaustive 0..255 loop and multi-cycle corner sequences.
module tb_dec_digit_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dec_digit_serializer_if bus();

  dec_digit_serializer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int    val;
    int    mode;
    string exp;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   rdy_mode = 0;
  byte  rx[$];
  int   acc_cyc[$];
  int   done_cnt = 0;
  int   done_cyc = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_char = 8'h00;
  vec_t tbl [7];

  task automatic chk(input string name, input int act,
                     input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name,
                         input string exp);
    string g = "";
    string w = "";
    bit ok;
    ok = (rx.size() == exp.len());
    foreach (rx[i]) g = $sformatf("%s%02x ", g, rx[i]);
    for (int i = 0; i < exp.len(); i++) begin
      w = $sformatf("%s%02x ", w, exp[i]);
      if (ok && rx[i] != exp[i]) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got [%s] want [%s]", name, g, w);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Sink ready pattern: 0 held high, 1 toggling, 2 held low
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.i_char_rdy = 1'b1;
      1:       bus.i_char_rdy = ~bus.i_char_rdy;
      default: bus.i_char_rdy = 1'b0;
    endcase
  end

  // Byte-stream monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (bus.o_char_stb && prev_stall)
        chk("stall_hold", int'(bus.o_char), int'(prev_char));
      if (bus.o_char_stb && bus.i_char_rdy) begin
        rx.push_back(bus.o_char);
        acc_cyc.push_back(cyc);
      end
      if (bus.o_done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      prev_stall <= bus.o_char_stb && !bus.i_char_rdy;
      prev_char  <= bus.o_char;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nsync();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] d);
    bus.i_digit    = d;
    bus.i_digit_rd = 1'b1;
    bus.i_conv_rd  = 1'b0;
    tick();
    bus.i_digit_rd = 1'b0;
  endtask

  task automatic send_num(input int v);
    int x = v;
    do begin
      push(4'(x % 10));
      x = x / 10;
    end while (x > 0);
    bus.i_conv_rd = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int start = done_cnt;
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      nsync();
      if (done_cnt != start) begin
        got = 1'b1;
        break;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL done_timeout: got 0 want 1");
    end
  endtask

  task automatic clear_rx();
    rx.delete();
    acc_cyc.delete();
  endtask

  initial begin
    tbl[0] = '{123, 0, "123\n"};
    tbl[1] = '{0,   0, "0\n"};
    tbl[2] = '{255, 1, "255\n"};
    tbl[3] = '{42,  0, "42\n"};
    tbl[4] = '{7,   1, "7\n"};
    tbl[5] = '{100, 0, "100\n"};
    tbl[6] = '{99,  1, "99\n"};

    rst            = 1'b1;
    bus.i_digit    = 4'h0;
    bus.i_digit_rd = 1'b0;
    bus.i_conv_rd  = 1'b1;
    rdy_mode       = 0;
    repeat (3) tick();
    nsync();
    chk("rst_char", int'(bus.o_char), 0);
    chk("rst_stb",  int'(bus.o_char_stb), 0);
    chk("rst_busy", int'(bus.o_busy), 0);
    chk("rst_done", int'(bus.o_done), 0);
    chk("rst_err",  int'(bus.o_err), 0);
    rst = 1'b0;

    repeat (4) nsync();
    chk("idle_stb",  int'(bus.o_char_stb), 0);
    chk("idle_busy", int'(bus.o_busy), 0);
    tick();

    for (int k = 0; k < 7; k++) begin
      clear_rx();
      rdy_mode = tbl[k].mode;
      send_num(tbl[k].val);
      wait_done(200);
      chk_str($sformatf("vec%0d_bytes", k), tbl[k].exp);
      chk($sformatf("vec%0d_busy", k), int'(bus.o_busy), 0);
      chk($sformatf("vec%0d_stb", k),
          int'(bus.o_char_stb), 0);
      chk($sformatf("vec%0d_err", k), int'(bus.o_err), 0);
      if (tbl[k].mode == 0 && acc_cyc.size() > 0) begin
        chk($sformatf("vec%0d_burst", k),
            acc_cyc[$] - acc_cyc[0], tbl[k].exp.len() - 1);
        chk($sformatf("vec%0d_done_lat", k),
            done_cyc - acc_cyc[$], 1);
      end
      tick();
    end

    rdy_mode = 0;
    for (int v = 0; v < 256; v++) begin
      clear_rx();
      send_num(v);
      wait_done(100);
      chk_str($sformatf("loop%0d", v),
              $sformatf("%0d\n", v));
      tick();
    end
    chk("loop_err", int'(bus.o_err), 0);

    clear_rx();
    send_num(123);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
        nsync();
        if (rx.size() >= 1) begin
          seen = 1'b1;
          break;
        end
      end
      chk("midemit_first_byte", int'(seen), 1);
    end
    @(posedge clk);
    #1;
    rst      = 1'b1;
    rdy_mode = 2;
    @(posedge clk);
    nsync();
    chk("mid_rst_char", int'(bus.o_char), 0);
    chk("mid_rst_stb",  int'(bus.o_char_stb), 0);
    chk("mid_rst_busy", int'(bus.o_busy), 0);
    chk("mid_rst_done", int'(bus.o_done), 0);
    chk("mid_rst_err",  int'(bus.o_err), 0);
    rst      = 1'b0;
    rdy_mode = 0;
    clear_rx();
    tick();
    send_num(42);
    wait_done(100);
    chk_str("after_rst_42", "42\n");
    tick();

    clear_rx();
    push(4'd4);
    push(4'd3);
    push(4'd2);
    push(4'd1);
    bus.i_conv_rd = 1'b1;
    wait_done(100);
    chk_str("overflow_bytes", "234\n");
    chk("overflow_err", int'(bus.o_err), 1);
    tick();

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    nsync();
    chk("err_cleared", int'(bus.o_err), 0);
    tick();
    clear_rx();
    push(4'd12);
    bus.i_conv_rd = 1'b1;
    wait_done(100);
    chk_str("bad_digit_bytes", "?\n");
    chk("bad_digit_err", int'(bus.o_err), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
